// File: rtl/bwt_pkg.sv
// Shared types for the BWT row sorter: row layout and merge-pass state encoding.
package bwt_pkg;

    localparam int COLUMN = 3;
    localparam int COL_W  = (COLUMN > 1) ? $clog2(COLUMN) : 1;

    // Byte 0 of a row sits in bits [7:0]; row[i] selects key column i.
    typedef logic [COLUMN-1:0][7:0] row_t;

    typedef enum logic [2:0] {
        IDLE,
        MERGE,
        DRAIN_A,
        DRAIN_B,
        FLUSH,
        DONE
    } merge_state_t;

endpackage

// File: rtl/merge_run_ctrl_if.sv
// Pass-control, run-FIFO and output-FIFO signals of one merge pass, bundled for merge_run_ctrl.
interface merge_run_ctrl_if
    import bwt_pkg::*;
#(
    parameter int CNT_W = 16
);

    logic             start;
    logic [CNT_W-1:0] run_len;
    logic [COL_W-1:0] sort_col;
    logic             busy;
    logic             done;

    logic             a_empty;
    row_t             a_data;
    logic             a_rd;
    logic             b_empty;
    row_t             b_data;
    logic             b_rd;

    logic             out_full;
    row_t             out_data;
    logic             out_wr;

    modport master (
        input  start, run_len, sort_col,
        input  a_empty, a_data, b_empty, b_data, out_full,
        output a_rd, b_rd, out_data, out_wr, busy, done
    );

    modport slave (
        output start, run_len, sort_col,
        output a_empty, a_data, b_empty, b_data, out_full,
        input  a_rd, b_rd, out_data, out_wr, busy, done
    );

endinterface

// File: rtl/merge_key_cmp.sv
// Key-column compare for the merge: picks run A when its key is less than or equal to run B's.
module merge_key_cmp
    import bwt_pkg::*;
(
    input  row_t             a_row,
    input  row_t             b_row,
    input  logic [COL_W-1:0] key_col,
    output logic             sel_a
);

    // <= rather than < keeps the merge stable: equal keys take A first.
    assign sel_a = (a_row[key_col] <= b_row[key_col]);

endmodule

// File: rtl/merge_run_ctrl.sv
// Sequences one merge pass: pops the smaller head of runs A/B into the output FIFO, then drains the survivor.
//   state   | meaning
//   IDLE    | waiting for start
//   MERGE   | both runs have rows left; compare heads, pop the winner
//   DRAIN_A | run B exhausted; copy remaining A rows
//   DRAIN_B | run A exhausted; copy remaining B rows
//   FLUSH   | last registered write lands
//   DONE    | one-cycle done pulse
module merge_run_ctrl
    import bwt_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    merge_run_ctrl_if.master bus
);

    localparam logic [COL_W:0] COL_LIM = (COL_W + 1)'(COLUMN);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    merge_state_t     state;
    merge_state_t     state_nxt;
    logic [CNT_W-1:0] rem_a;
    logic [CNT_W-1:0] rem_b;
    logic [COL_W-1:0] key_col;
    logic             sel_a;
    logic             pop_a;
    logic             pop_b;
    row_t             out_data_q;
    logic             out_wr_q;

    merge_key_cmp u_cmp (
        .a_row   (bus.a_data),
        .b_row   (bus.b_data),
        .key_col (key_col),
        .sel_a   (sel_a)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop_a     = 1'b0;
        pop_b     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = (bus.run_len == '0) ? DONE : MERGE;
                end
            end
            MERGE: begin
                // Both heads must be present even though only one is popped.
                if (!bus.a_empty && !bus.b_empty && !bus.out_full) begin
                    if (sel_a) begin
                        pop_a = 1'b1;
                        if (rem_a == ONE) state_nxt = DRAIN_B;
                    end else begin
                        pop_b = 1'b1;
                        if (rem_b == ONE) state_nxt = DRAIN_A;
                    end
                end
            end
            DRAIN_A: begin
                if (!bus.a_empty && !bus.out_full) begin
                    pop_a = 1'b1;
                    if (rem_a == ONE) state_nxt = FLUSH;
                end
            end
            DRAIN_B: begin
                if (!bus.b_empty && !bus.out_full) begin
                    pop_b = 1'b1;
                    if (rem_b == ONE) state_nxt = FLUSH;
                end
            end
            FLUSH:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_a      <= '0;
            rem_b      <= '0;
            key_col    <= '0;
            out_data_q <= '0;
            out_wr_q   <= 1'b0;
        end else begin
            out_wr_q <= pop_a | pop_b;
            if (pop_a) begin
                out_data_q <= bus.a_data;
                rem_a      <= rem_a - ONE;
            end else if (pop_b) begin
                out_data_q <= bus.b_data;
                rem_b      <= rem_b - ONE;
            end
            if (state == IDLE && bus.start) begin
                rem_a   <= bus.run_len;
                rem_b   <= bus.run_len;
                key_col <= bus.sort_col;
            end
        end
    end

    assign bus.a_rd     = pop_a;
    assign bus.b_rd     = pop_b;
    assign bus.out_data = out_data_q;
    assign bus.out_wr   = out_wr_q;
    assign bus.busy     = (state == MERGE) || (state == DRAIN_A) ||
                          (state == DRAIN_B) || (state == FLUSH);
    assign bus.done     = (state == DONE);

    a_sort_col_range: assert property (
        @(posedge clk) disable iff (!rst_n)
        (state == IDLE && bus.start) |-> ({1'b0, bus.sort_col} < COL_LIM)
    );

endmodule

// File: tb/tb_merge_run_ctrl.sv
// Directed bench for merge_run_ctrl: FWFT run FIFO models, output capture and protocol monitors.
module tb_merge_run_ctrl;
    import bwt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    merge_run_ctrl_if #(.CNT_W(16)) bus ();

    merge_run_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Run FIFO models: rows [ptr, end) are queued; hold forces empty.
    row_t a_mem [64];
    row_t b_mem [64];
    int   a_ptr = 0, b_ptr = 0, a_end = 0, b_end = 0;
    logic a_hold = 1'b0, b_hold = 1'b0;
    int   cyc = 0;

    assign bus.a_empty = (a_ptr >= a_end) || a_hold;
    assign bus.b_empty = (b_ptr >= b_end) || b_hold;
    assign bus.a_data  = a_mem[a_ptr[5:0]];
    assign bus.b_data  = b_mem[b_ptr[5:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.a_rd) a_ptr <= a_ptr + 1;
        if (bus.b_rd) b_ptr <= b_ptr + 1;
    end

    row_t       wr_q[$];
    int         wr_cyc[$];
    logic [7:0] pop_q[$];
    int         pop_cyc[$];
    int         done_cyc = -1, done_cnt = 0;
    int         both_err = 0, empty_err = 0, full_err = 0, merge_err = 0, stall_wr_err = 0;
    logic       full_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.out_wr) begin
            wr_q.push_back(bus.out_data);
            wr_cyc.push_back(cyc);
            if (full_prev) stall_wr_err <= stall_wr_err + 1;
        end
        if (bus.a_rd) begin
            pop_q.push_back(8'hA);
            pop_cyc.push_back(cyc);
        end
        if (bus.b_rd) begin
            pop_q.push_back(8'hB);
            pop_cyc.push_back(cyc);
        end
        if (bus.a_rd && bus.b_rd) both_err <= both_err + 1;
        if ((bus.a_rd && bus.a_empty) || (bus.b_rd && bus.b_empty)) empty_err <= empty_err + 1;
        if ((bus.a_rd || bus.b_rd) && bus.out_full) full_err <= full_err + 1;
        // While both runs still hold rows, neither may pop with the other head missing.
        if ((bus.a_rd && bus.b_empty && b_ptr < b_end) ||
            (bus.b_rd && bus.a_empty && a_ptr < a_end)) merge_err <= merge_err + 1;
        if (bus.done) begin
            done_cyc <= cyc;
            done_cnt <= done_cnt + 1;
        end
        full_prev <= bus.out_full;
    end

    int last_start_c = 0;

    function automatic row_t mk(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        row_t r;
        r[0] = b0;
        r[1] = b1;
        r[2] = b2;
        return r;
    endfunction

    task automatic push_a(input row_t r);
        a_mem[a_end[5:0]] = r;
        a_end = a_end + 1;
    endtask

    task automatic push_b(input row_t r);
        b_mem[b_end[5:0]] = r;
        b_end = b_end + 1;
    endtask

    task automatic pulse_start(input logic [15:0] len, input logic [COL_W-1:0] col);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.run_len  = len;
        bus.sort_col = col;
        last_start_c = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.run_len = '0; bus.sort_col = '0; bus.out_full = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_wr !== 1'b0) begin failures++; $display("FAIL reset_out_wr: got %b want 0", bus.out_wr); end
        checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if ({bus.a_rd, bus.b_rd} !== 2'b00) begin failures++; $display("FAIL reset_rd: got %b want 00", {bus.a_rd, bus.b_rd}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        row_t exp [6];
        int   wb, pb, dc0;
        bit   seen;
        wb = wr_q.size(); pb = pop_q.size(); dc0 = done_cnt;
        push_a(mk(8'd1, 8'hA0, 8'h31)); push_a(mk(8'd4, 8'hA1, 8'h32)); push_a(mk(8'd9, 8'hA2, 8'h33));
        push_b(mk(8'd2, 8'hB0, 8'h41)); push_b(mk(8'd3, 8'hB1, 8'h42)); push_b(mk(8'd10, 8'hB2, 8'h43));
        exp = '{mk(8'd1, 8'hA0, 8'h31), mk(8'd2, 8'hB0, 8'h41), mk(8'd3, 8'hB1, 8'h42),
                mk(8'd4, 8'hA1, 8'h32), mk(8'd9, 8'hA2, 8'h33), mk(8'd10, 8'hB2, 8'h43)};
        pulse_start(16'd3, '0);
        wait_done(60, seen);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (!seen) begin failures++; $display("FAIL basic_done_seen: got 0 want 1"); end
        checks++; if (wr_q.size() - wb !== 6) begin failures++; $display("FAIL basic_wr_count: got %0d want 6", wr_q.size() - wb); end
        for (int i = 0; i < 6; i++) begin
            if (wb + i < wr_q.size()) begin
                checks++;
                if (wr_q[wb + i] !== exp[i]) begin failures++; $display("FAIL basic_row%0d: got %h want %h", i, wr_q[wb + i], exp[i]); end
            end
        end
        if (wr_q.size() - wb == 6 && pop_q.size() - pb == 6) begin
            checks++; if (pop_cyc[pb] !== last_start_c + 1) begin failures++; $display("FAIL basic_first_pop: got cyc %0d want %0d", pop_cyc[pb], last_start_c + 1); end
            checks++; if (wr_cyc[wb] - pop_cyc[pb] !== 1) begin failures++; $display("FAIL basic_latency: got %0d want 1", wr_cyc[wb] - pop_cyc[pb]); end
            checks++; if (wr_cyc[wb + 5] - wr_cyc[wb] !== 5) begin failures++; $display("FAIL basic_back_to_back: got span %0d want 5", wr_cyc[wb + 5] - wr_cyc[wb]); end
            checks++; if (done_cyc - pop_cyc[pb + 5] !== 2) begin failures++; $display("FAIL basic_done_delay: got %0d want 2", done_cyc - pop_cyc[pb + 5]); end
        end
        checks++; if (done_cnt - dc0 !== 1) begin failures++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - dc0); end
    endtask

    task automatic test_ties;
        row_t exp [4];
        int   wb, be0;
        bit   seen;
        wb = wr_q.size(); be0 = both_err;
        push_a(mk(8'hA0, 8'd5, 8'h00)); push_a(mk(8'hA1, 8'd5, 8'h00));
        push_b(mk(8'hB0, 8'd5, 8'h00)); push_b(mk(8'hB1, 8'd5, 8'h00));
        exp = '{mk(8'hA0, 8'd5, 8'h00), mk(8'hA1, 8'd5, 8'h00), mk(8'hB0, 8'd5, 8'h00), mk(8'hB1, 8'd5, 8'h00)};
        pulse_start(16'd2, 2'd1);
        wait_done(60, seen);
        checks++; if (!seen) begin failures++; $display("FAIL ties_done_seen: got 0 want 1"); end
        checks++; if (wr_q.size() - wb !== 4) begin failures++; $display("FAIL ties_wr_count: got %0d want 4", wr_q.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            if (wb + i < wr_q.size()) begin
                checks++;
                if (wr_q[wb + i] !== exp[i]) begin failures++; $display("FAIL ties_row%0d: got %h want %h", i, wr_q[wb + i], exp[i]); end
            end
        end
        checks++; if (both_err !== be0) begin failures++; $display("FAIL ties_both_rd: got %0d want %0d", both_err, be0); end
    endtask

    task automatic test_drain;
        logic [7:0] exp_pop [6];
        int         wb, pb;
        bit         seen;
        wb = wr_q.size(); pb = pop_q.size();
        push_a(mk(8'd1, 8'hA0, 8'h00)); push_a(mk(8'd2, 8'hA1, 8'h00)); push_a(mk(8'd3, 8'hA2, 8'h00));
        push_b(mk(8'd7, 8'hB0, 8'h00)); push_b(mk(8'd8, 8'hB1, 8'h00)); push_b(mk(8'd9, 8'hB2, 8'h00));
        exp_pop = '{8'hA, 8'hA, 8'hA, 8'hB, 8'hB, 8'hB};
        pulse_start(16'd3, '0);
        wait_done(60, seen);
        checks++; if (!seen) begin failures++; $display("FAIL drain_done_seen: got 0 want 1"); end
        checks++; if (wr_q.size() - wb !== 6) begin failures++; $display("FAIL drain_wr_count: got %0d want 6", wr_q.size() - wb); end
        for (int i = 0; i < 6; i++) begin
            if (pb + i < pop_q.size()) begin
                checks++;
                if (pop_q[pb + i] !== exp_pop[i]) begin failures++; $display("FAIL drain_pop%0d: got %h want %h", i, pop_q[pb + i], exp_pop[i]); end
            end
        end
        if (wb + 5 < wr_q.size()) begin
            checks++; if (wr_q[wb + 3] !== mk(8'd7, 8'hB0, 8'h00)) begin failures++; $display("FAIL drain_row3: got %h want %h", wr_q[wb + 3], mk(8'd7, 8'hB0, 8'h00)); end
            checks++; if (wr_q[wb + 5] !== mk(8'd9, 8'hB2, 8'h00)) begin failures++; $display("FAIL drain_row5: got %h want %h", wr_q[wb + 5], mk(8'd9, 8'hB2, 8'h00)); end
        end
    endtask

    task automatic test_backpressure;
        row_t exp [6];
        int   wb, fe0, ee0, me0, se0;
        bit   seen;
        wb = wr_q.size(); fe0 = full_err; ee0 = empty_err; me0 = merge_err; se0 = stall_wr_err;
        push_a(mk(8'd1, 8'hA0, 8'h31)); push_a(mk(8'd4, 8'hA1, 8'h32)); push_a(mk(8'd9, 8'hA2, 8'h33));
        push_b(mk(8'd2, 8'hB0, 8'h41)); push_b(mk(8'd3, 8'hB1, 8'h42)); push_b(mk(8'd10, 8'hB2, 8'h43));
        exp = '{mk(8'd1, 8'hA0, 8'h31), mk(8'd2, 8'hB0, 8'h41), mk(8'd3, 8'hB1, 8'h42),
                mk(8'd4, 8'hA1, 8'h32), mk(8'd9, 8'hA2, 8'h33), mk(8'd10, 8'hB2, 8'h43)};
        pulse_start(16'd3, '0);
        @(posedge clk); #1;
        bus.out_full = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        bus.out_full = 1'b0;
        repeat (6) begin @(posedge clk); #1; b_hold = ~b_hold; end
        b_hold = 1'b0;
        wait_done(80, seen);
        checks++; if (!seen) begin failures++; $display("FAIL bp_done_seen: got 0 want 1"); end
        checks++; if (wr_q.size() - wb !== 6) begin failures++; $display("FAIL bp_wr_count: got %0d want 6", wr_q.size() - wb); end
        for (int i = 0; i < 6; i++) begin
            if (wb + i < wr_q.size()) begin
                checks++;
                if (wr_q[wb + i] !== exp[i]) begin failures++; $display("FAIL bp_row%0d: got %h want %h", i, wr_q[wb + i], exp[i]); end
            end
        end
        if (wr_q.size() - wb == 6) begin
            checks++; if (wr_cyc[wb + 5] - wr_cyc[wb] !== 12) begin failures++; $display("FAIL bp_span: got %0d want 12", wr_cyc[wb + 5] - wr_cyc[wb]); end
        end
        checks++; if (full_err !== fe0) begin failures++; $display("FAIL bp_pop_while_full: got %0d want %0d", full_err, fe0); end
        checks++; if (stall_wr_err !== se0) begin failures++; $display("FAIL bp_write_while_stalled: got %0d want %0d", stall_wr_err, se0); end
        checks++; if (empty_err !== ee0) begin failures++; $display("FAIL bp_pop_empty: got %0d want %0d", empty_err, ee0); end
        checks++; if (merge_err !== me0) begin failures++; $display("FAIL bp_merge_one_head: got %0d want %0d", merge_err, me0); end
    endtask

    task automatic test_zero_and_busy;
        row_t exp [4];
        int   wb, pb, dc0;
        bit   seen;
        wb = wr_q.size(); pb = pop_q.size();
        pulse_start(16'd0, '0);
        wait_done(10, seen);
        checks++; if (!seen) begin failures++; $display("FAIL zero_done_seen: got 0 want 1"); end
        checks++; if (done_cyc !== last_start_c + 1) begin failures++; $display("FAIL zero_done_cycle: got %0d want %0d", done_cyc, last_start_c + 1); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (pop_q.size() !== pb || wr_q.size() !== wb) begin failures++; $display("FAIL zero_activity: got pops %0d writes %0d want 0 0", pop_q.size() - pb, wr_q.size() - wb); end

        wb = wr_q.size(); dc0 = done_cnt;
        push_a(mk(8'd1, 8'hF0, 8'h00)); push_a(mk(8'd2, 8'hF1, 8'h00));
        push_b(mk(8'd3, 8'h10, 8'h00)); push_b(mk(8'd4, 8'h11, 8'h00));
        exp = '{mk(8'd1, 8'hF0, 8'h00), mk(8'd2, 8'hF1, 8'h00), mk(8'd3, 8'h10, 8'h00), mk(8'd4, 8'h11, 8'h00)};
        pulse_start(16'd2, '0);
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_mid_pass: got %b want 1", bus.busy); end
        bus.start = 1'b1; bus.run_len = 16'd5; bus.sort_col = 2'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(60, seen);
        repeat (6) @(negedge clk);
        #1;
        checks++; if (!seen) begin failures++; $display("FAIL busy_done_seen: got 0 want 1"); end
        checks++; if (wr_q.size() - wb !== 4) begin failures++; $display("FAIL busy_wr_count: got %0d want 4", wr_q.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            if (wb + i < wr_q.size()) begin
                checks++;
                if (wr_q[wb + i] !== exp[i]) begin failures++; $display("FAIL busy_row%0d: got %h want %h", i, wr_q[wb + i], exp[i]); end
            end
        end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_after_done: got %b want 0", bus.busy); end
        checks++; if (done_cnt - dc0 !== 1) begin failures++; $display("FAIL busy_done_pulses: got %0d want 1", done_cnt - dc0); end
    endtask

    task automatic test_reset_mid;
        row_t exp [4];
        int   wb;
        bit   got2, seen;
        wb = wr_q.size(); got2 = 1'b0;
        push_a(mk(8'd1, 8'hA0, 8'h00)); push_a(mk(8'd3, 8'hA1, 8'h00)); push_a(mk(8'd5, 8'hA2, 8'h00)); push_a(mk(8'd7, 8'hA3, 8'h00));
        push_b(mk(8'd2, 8'hB0, 8'h00)); push_b(mk(8'd4, 8'hB1, 8'h00)); push_b(mk(8'd6, 8'hB2, 8'h00)); push_b(mk(8'd8, 8'hB3, 8'h00));
        pulse_start(16'd4, '0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (wr_q.size() - wb >= 2) begin got2 = 1'b1; break; end
        end
        checks++; if (!got2) begin failures++; $display("FAIL rst_mid_second_write: got %0d writes want 2", wr_q.size() - wb); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_wr !== 1'b0) begin failures++; $display("FAIL rst_mid_out_wr: got %b want 0", bus.out_wr); end
        checks++; if (bus.out_data !== '0) begin failures++; $display("FAIL rst_mid_out_data: got %h want 0", bus.out_data); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL rst_mid_busy_done: got %b%b want 00", bus.busy, bus.done); end
        checks++; if ({bus.a_rd, bus.b_rd} !== 2'b00) begin failures++; $display("FAIL rst_mid_rd: got %b want 00", {bus.a_rd, bus.b_rd}); end
        @(negedge clk); #1;
        rst_n = 1'b1;
        a_end = a_ptr; b_end = b_ptr;
        repeat (2) @(negedge clk);
        wb = wr_q.size();
        push_a(mk(8'd10, 8'hC0, 8'h00)); push_a(mk(8'd20, 8'hC1, 8'h00));
        push_b(mk(8'd15, 8'hD0, 8'h00)); push_b(mk(8'd25, 8'hD1, 8'h00));
        exp = '{mk(8'd10, 8'hC0, 8'h00), mk(8'd15, 8'hD0, 8'h00), mk(8'd20, 8'hC1, 8'h00), mk(8'd25, 8'hD1, 8'h00)};
        pulse_start(16'd2, '0);
        wait_done(60, seen);
        checks++; if (!seen) begin failures++; $display("FAIL rst_fresh_done_seen: got 0 want 1"); end
        checks++; if (wr_q.size() - wb !== 4) begin failures++; $display("FAIL rst_fresh_wr_count: got %0d want 4", wr_q.size() - wb); end
        for (int i = 0; i < 4; i++) begin
            if (wb + i < wr_q.size()) begin
                checks++;
                if (wr_q[wb + i] !== exp[i]) begin failures++; $display("FAIL rst_fresh_row%0d: got %h want %h", i, wr_q[wb + i], exp[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_drain();
        test_backpressure();
        test_zero_and_busy();
        test_reset_mid();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (both_err !== 0) begin failures++; $display("FAIL global_both_rd: got %0d want 0", both_err); end
        checks++; if (empty_err !== 0) begin failures++; $display("FAIL global_pop_empty: got %0d want 0", empty_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
